// File: rtl/if_fetch.sv
// Instruction fetch stage: program counter, req/ack instruction-memory port, decode slot
// with a one-entry skid register, jump redirect flush and halt.
module if_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic [7:0] inst,
  output logic [7:0] PC,
  output logic       inst_valid,
  input  logic       id_ready,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  input  logic       halt,
  output logic       halted
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, r_addr, r_inst, r_pc_out, r_skid_inst, r_skid_pc;
  logic       r_valid, r_skid_valid, r_halt_pend, w_halt_pend_nxt;
  logic       w_slot_free, w_consume, w_req, w_capture, w_flush;

  assign w_slot_free = !r_valid || id_ready;
  assign w_consume   = r_valid && id_ready;
  assign w_flush     = redirect && (r_state != S_HALT);

  always_comb begin
    w_state_nxt     = r_state;
    w_halt_pend_nxt = r_halt_pend;
    w_req           = 1'b0;
    w_capture       = 1'b0;
    case (r_state)
      S_REQ: begin
        // Reset gates the request combinationally so it drops the moment reset rises.
        w_req     = w_slot_free && !r_skid_valid && !reset;
        w_capture = w_req && imem_ack && !redirect;
        if (w_req && !imem_ack) begin
          w_state_nxt     = redirect ? S_DRAIN : S_WAIT;
          w_halt_pend_nxt = halt;
        end else if (halt) begin
          w_state_nxt = S_HALT;
        end
      end
      S_WAIT, S_DRAIN: begin
        w_req     = 1'b1;
        w_capture = (r_state == S_WAIT) && imem_ack && !redirect;
        if (imem_ack) begin
          w_state_nxt     = (halt || r_halt_pend) ? S_HALT : S_REQ;
          w_halt_pend_nxt = 1'b0;
        end else begin
          if (redirect) w_state_nxt = S_DRAIN;
          if (halt) w_halt_pend_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_halt_pend  <= 1'b0;
      r_pc         <= RESET_PC;
      r_pc_out     <= RESET_PC;
      r_inst       <= 8'h00;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      if (w_flush) begin
        r_pc         <= redirect_pc;
        r_valid      <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_capture && w_slot_free) begin
        r_pc     <= imem_addr + 8'd1;
        r_inst   <= imem_rdata;
        r_pc_out <= imem_addr;
        r_valid  <= 1'b1;
      end else if (w_capture) begin
        r_pc         <= imem_addr + 8'd1;
        r_skid_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid      <= r_skid_valid;
        r_skid_valid <= 1'b0;
        if (r_skid_valid) begin
          r_inst   <= r_skid_inst;
          r_pc_out <= r_skid_pc;
        end
      end
    end
  end

  // Address of the outstanding request stays put while waiting, even after a redirect.
  always_ff @(posedge clock) begin
    r_addr <= imem_addr;
    if (w_capture && !w_slot_free) begin
      r_skid_inst <= imem_rdata;
      r_skid_pc   <= imem_addr;
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = (r_state == S_WAIT || r_state == S_DRAIN) ? r_addr : r_pc;
  assign inst       = r_inst;
  assign PC         = r_pc_out;
  assign inst_valid = r_valid;
  assign halted     = (r_state == S_HALT);
endmodule
